alu_pipe: RTL and testbench

- Parametrised, clocked successor to the datapath ALU.
- W-bit operands; registered result and flags; valid/ready handshakes on input and output.
- Adds OR, rotate-right, compare, signed-overflow/negative flags, and a multi-cycle shift-add multiply with a 2W-bit product.
- Sits between the register-file read stage and writeback; carry in/out supports multi-precision chaining by the controller.

---
 rtl/alu_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU: registered result/flags behind valid/ready handshakes, with a
// radix-2 shift-add multiplier that holds the input side for W cycles.
module alu_pipe #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic         sc_o,
  output logic         zero,
  output logic         pari,
  output logic         neg,
  output logic         ovf,
  output logic         illegal
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SHL = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_ROL = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_PAS = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic parity_f(input logic [2*W-1:0] v);
    return ^v;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   ma_q, ma_d, mhi_q, mhi_d, mlo_q, mlo_d;
  logic [W-1:0]   rslt_q, rslt_d, rslt_hi_q, rslt_hi_d;
  logic           sc_q, sc_d, zero_q, zero_d, pari_q, pari_d;
  logic           neg_q, neg_d, ovf_q, ovf_d, ill_q, ill_d, vld_q, vld_d;

  logic           in_ready_s, accept_s;
  logic [W:0]     add_s, sub_s, step_s;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   alu_r_s, alu_flag_s;
  logic           alu_c_s, alu_o_s, alu_ill_s;

  assign in_ready_s = (state_q == IDLE) && (!vld_q || out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Single-cycle datapath evaluated straight from the offered operands
  always_comb begin
    add_s      = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
    sub_s      = {1'b0, inA} + {1'b0, ~inB} + {{W{1'b0}}, sc_i};
    alu_r_s    = {W{1'b0}};
    alu_c_s    = 1'b0;
    alu_o_s    = 1'b0;
    alu_ill_s  = 1'b0;
    case (alu_cmd)
      OP_ADD: begin
        alu_r_s = add_s[W-1:0];
        alu_c_s = add_s[W];
        alu_o_s = (inA[W-1] == inB[W-1]) && (add_s[W-1] != inA[W-1]);
      end
      OP_SHL: begin
        alu_r_s = {inA[W-2:0], sc_i};
        alu_c_s = inA[W-1];
      end
      OP_SHR: begin
        alu_r_s = {sc_i, inA[W-1:1]};
        alu_c_s = inA[0];
      end
      OP_XOR: alu_r_s = inA ^ inB;
      OP_AND: alu_r_s = inA & inB;
      OP_ROL: alu_r_s = {inA[W-2:0], inA[W-1]};
      OP_SUB: begin
        alu_r_s = sub_s[W-1:0];
        alu_c_s = sub_s[W];
        alu_o_s = (inA[W-1] == ~inB[W-1]) && (sub_s[W-1] != inA[W-1]);
      end
      OP_PAS: alu_r_s = inA;
      OP_OR:  alu_r_s = inA | inB;
      OP_ROR: alu_r_s = {inA[0], inA[W-1:1]};
      OP_MUL: alu_r_s = {W{1'b0}};
      OP_CMP: begin
        alu_c_s = sub_s[W];
        alu_o_s = (inA[W-1] == ~inB[W-1]) && (sub_s[W-1] != inA[W-1]);
      end
      default: alu_ill_s = 1'b1;
    endcase
    // CMP discards the difference but its flags still describe it
    alu_flag_s = (alu_cmd == OP_CMP) ? sub_s[W-1:0] : alu_r_s;
  end

  // Handshake, multiply FSM and result-register next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ma_d      = ma_q;
    mhi_d     = mhi_q;
    mlo_d     = mlo_q;
    rslt_d    = rslt_q;
    rslt_hi_d = rslt_hi_q;
    sc_d      = sc_q;
    zero_d    = zero_q;
    pari_d    = pari_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    ill_d     = ill_q;
    step_s    = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, ma_q} : {(W+1){1'b0}});
    prod_s    = {step_s, mlo_q[W-1:1]};
    if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s && (alu_cmd == OP_MUL)) begin
          state_d = MUL;
          cnt_d   = CW'(W - 1);
          ma_d    = inA;
          mhi_d   = {W{1'b0}};
          mlo_d   = inB;
        end else if (accept_s) begin
          rslt_d    = alu_r_s;
          rslt_hi_d = {W{1'b0}};
          sc_d      = alu_c_s;
          zero_d    = (alu_flag_s == {W{1'b0}});
          pari_d    = parity_f({{W{1'b0}}, alu_flag_s});
          neg_d     = alu_flag_s[W-1];
          ovf_d     = alu_o_s;
          ill_d     = alu_ill_s;
          vld_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        // Add multiplicand into the high half when the current multiplier bit is set, then shift right
        mhi_d = step_s[W:1];
        mlo_d = {step_s[0], mlo_q[W-1:1]};
        if (cnt_q == {CW{1'b0}}) begin
          state_d   = IDLE;
          rslt_d    = prod_s[W-1:0];
          rslt_hi_d = prod_s[2*W-1:W];
          sc_d      = 1'b0;
          zero_d    = (prod_s == {(2*W){1'b0}});
          pari_d    = parity_f(prod_s);
          neg_d     = prod_s[2*W-1];
          ovf_d     = 1'b0;
          ill_d     = 1'b0;
          vld_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiply controller and working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      ma_q    <= {W{1'b0}};
      mhi_q   <= {W{1'b0}};
      mlo_q   <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mhi_q   <= mhi_d;
      mlo_q   <= mlo_d;
    end
  end

  // Result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rslt_q    <= {W{1'b0}};
      rslt_hi_q <= {W{1'b0}};
      sc_q      <= 1'b0;
      zero_q    <= 1'b0;
      pari_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ill_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      rslt_q    <= rslt_d;
      rslt_hi_q <= rslt_hi_d;
      sc_q      <= sc_d;
      zero_q    <= zero_d;
      pari_q    <= pari_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      ill_q     <= ill_d;
      vld_q     <= vld_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = vld_q;
  assign rslt      = rslt_q;
  assign rslt_hi   = rslt_hi_q;
  assign sc_o      = sc_q;
  assign zero      = zero_q;
  assign pari      = pari_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, sc_i, out_valid, out_ready;
  logic [3:0]   alu_cmd;
  logic [W-1:0] inA, inB, rslt, rslt_hi;
  logic         sc_o, zero, pari, neg, ovf, illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic c, z, p, n, o, il;
  } exp_t;

  alu_pipe #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt), .rslt_hi(rslt_hi),
    .sc_o(sc_o), .zero(zero), .pari(pari), .neg(neg), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic int sgn(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  // Reference: plain integer arithmetic on the opcode definitions
  function automatic exp_t model(input int cmd, input int a, input int b, input int sc);
    exp_t   e;
    int     mask, s, flagv, sr;
    longint p;
    mask  = (1 << W) - 1;
    e     = '0;
    s     = 0;
    flagv = 0;
    sr    = 0;
    case (cmd)
      0: begin
        s = a + b + sc; e.r = W'(s & mask); e.c = 1'((s >> W) & 1); flagv = s & mask;
        sr = sgn(a) + sgn(b) + sc;
        e.o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      end
      1: begin flagv = ((a << 1) | sc) & mask; e.c = 1'((a >> (W - 1)) & 1); end
      2: begin flagv = (sc << (W - 1)) | (a >> 1); e.c = 1'(a & 1); end
      3: flagv = a ^ b;
      4: flagv = a & b;
      5: flagv = ((a << 1) | (a >> (W - 1))) & mask;
      6, 11: begin
        s = a + (mask - b) + sc; e.c = 1'((s >> W) & 1); flagv = s & mask;
        sr = sgn(a) + (-sgn(b) - 1) + sc;
        e.o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.r = (cmd == 6) ? W'(s & mask) : {W{1'b0}};
      end
      7: flagv = a;
      8: flagv = a | b;
      9: flagv = (a >> 1) | ((a & 1) << (W - 1));
      10: begin
        p    = longint'(a) * longint'(b);
        e.r  = W'(p & mask);
        e.hi = W'((p >> W) & mask);
        e.z  = (p == 0);
        e.p  = 1'($countones(p) & 1);
        e.n  = 1'((p >> (2 * W - 1)) & 1);
      end
      default: e.il = 1'b1;
    endcase
    if (cmd != 10) begin
      if (cmd != 6 && cmd != 11 && cmd != 0) e.r = W'(flagv);
      e.z = (flagv == 0);
      e.p = 1'($countones(flagv) & 1);
      e.n = 1'((flagv >> (W - 1)) & 1);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".rslt"}, 32'(rslt), 32'(e.r));
    chk({tag, ".rslt_hi"}, 32'(rslt_hi), 32'(e.hi));
    chk({tag, ".sc_o"}, 32'(sc_o), 32'(e.c));
    chk({tag, ".zero"}, 32'(zero), 32'(e.z));
    chk({tag, ".pari"}, 32'(pari), 32'(e.p));
    chk({tag, ".neg"}, 32'(neg), 32'(e.n));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e.o));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e.il));
  endtask

  // Call just after a falling edge; returns 1 time unit after the accepting edge
  task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sc);
    int n;
    n = 0;
    alu_cmd = cmd; inA = a; inB = b; sc_i = sc; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk); n++;
    end
    chk("result_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain", 32'(out_valid), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   cmd, a, b, sc, st;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_cmd = 4'd0; inA = '0; inB = '0; sc_i = 1'b0;
    #2;
    check_all("reset", '0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Reset while a multiply is in flight
    send(4'd10, 8'h12, 8'h34, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk("rstmul.out_valid", 32'(out_valid), 32'd0);
    chk("rstmul.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rstmul.no_stray", 32'(out_valid), 32'd0);
    end

    // ADD carry and signed overflow
    send(4'd0, 8'hFF, 8'h01, 1'b0); wait_result();
    check_all("add_ff_01", model(0, 'hFF, 'h01, 0));
    chk("add_ff_01.zero_direct", 32'(zero), 32'd1);
    consume();
    send(4'd0, 8'h7F, 8'h01, 1'b0); wait_result();
    check_all("add_7f_01", model(0, 'h7F, 'h01, 0));
    chk("add_7f_01.rslt_direct", 32'(rslt), 32'h80);
    chk("add_7f_01.ovf_direct", 32'(ovf), 32'd1);
    consume();

    // SUB with borrow, CMP equal
    send(4'd6, 8'h05, 8'h07, 1'b1); wait_result();
    check_all("sub_05_07", model(6, 'h05, 'h07, 1));
    chk("sub_05_07.rslt_direct", 32'(rslt), 32'hFE);
    consume();
    send(4'd11, 8'h07, 8'h07, 1'b1); wait_result();
    check_all("cmp_07_07", model(11, 'h07, 'h07, 1));
    chk("cmp_07_07.sc_direct", 32'(sc_o), 32'd1);
    consume();

    // MUL latency: out_valid exactly W cycles after acceptance
    send(4'd10, 8'hFF, 8'hFF, 1'b0);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("mul.busy_valid", 32'(out_valid), 32'd0);
      chk("mul.busy_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("mul.valid_at_W", 32'(out_valid), 32'd1);
    chk("mul.ready_held", 32'(in_ready), 32'd0);
    check_all("mul_ff_ff", model(10, 'hFF, 'hFF, 0));
    chk("mul.hi_direct", 32'(rslt_hi), 32'hFE);
    consume();

    // Backpressure: result held, pending op waits for out_ready
    send(4'd1, 8'h81, 8'h00, 1'b1);
    alu_cmd = 4'd0; inA = 8'h10; inB = 8'h20; sc_i = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_all("bp_hold", model(1, 'h81, 0, 1));
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp.ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_next.out_valid", 32'(out_valid), 32'd1);
    check_all("bp_next", model(0, 'h10, 'h20, 0));
    consume();

    // Streaming at full throughput
    out_ready = 1'b1;
    alu_cmd = 4'd9; inA = 8'h01; inB = 8'h00; sc_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("stream1.valid", 32'(out_valid), 32'd1);
    check_all("stream_ror", model(9, 'h01, 0, 0));
    alu_cmd = 4'd5; inA = 8'h80;
    @(negedge clk);
    chk("stream2.valid", 32'(out_valid), 32'd1);
    check_all("stream_rol", model(5, 'h80, 0, 0));
    alu_cmd = 4'd13;
    @(negedge clk);
    chk("stream3.valid", 32'(out_valid), 32'd1);
    check_all("stream_ill", model(13, 'h80, 0, 0));
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream.drain", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Randomized operations with random consumer stalls
    for (int i = 0; i < 60; i++) begin
      cmd = int'($urandom_range(0, 15));
      a   = int'($urandom_range(0, (1 << W) - 1));
      b   = int'($urandom_range(0, (1 << W) - 1));
      sc  = int'($urandom_range(0, 1));
      st  = int'($urandom_range(0, 3));
      e   = model(cmd, a, b, sc);
      send(4'(cmd), W'(a), W'(b), 1'(sc));
      wait_result();
      check_all($sformatf("rand%0d_op%0d", i, cmd), e);
      for (int k = 0; k < st; k++) begin
        @(negedge clk);
        chk("rand.hold", 32'(rslt), 32'(e.r));
      end
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end
endmodule
